// File: rtl/uart_pkg.sv
// Shared UART definitions: baud defaults, the divisor helper and the line-FSM
// state encoding used by both the transmitter and the receiver.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit period, rounded down.
  function automatic int baud_cnt(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is a parameter so idle-high lines and active-low keys can both use it.
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments make meta->q a real two-stage pipeline.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: start-bit detection, mid-bit sampling,
// stop-bit check, one-cycle done/error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF,
  parameter int CNT_MAX  = baud_cnt(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       done_rx,
  output logic       err_frame,
  output logic       busy_rx
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CNT_MAX / 2 - 1);

  logic             rx_s;
  logic             rx_d;
  logic             fall;
  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  bit_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_d <= 1'b1;
    else        rx_d <= rx_s;
  end

  assign fall    = rx_d & ~rx_s;
  assign busy_rx = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_rx   <= '0;
      done_rx   <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so a pulse can only last one clock.
      done_rx   <= 1'b0;
      err_frame <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            // A line already back high at mid start bit was only a glitch.
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // Leave at mid stop bit so an immediately following start is caught.
            state <= IDLE;
            if (rx_s) begin
              data_rx <= shreg;
              done_rx <= 1'b1;
            end else begin
              err_frame <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a bench-side UART line driver, a monitor that
// logs strobes, and an expected-byte list built from the frame format.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115_200;
  localparam int CNT      = 16;
  localparam int HALF     = CNT / 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_rx;
  logic       done_rx;
  logic       err_frame;
  logic       busy_rx;

  int tests = 0;
  int fails = 0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_rx   (data_rx),
    .done_rx   (done_rx),
    .err_frame (err_frame),
    .busy_rx   (busy_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: logs every strobe cycle and flags protocol violations.
  logic [7:0] got_mem [0:255];
  int         got_n     = 0;
  int         err_n     = 0;
  int         both_n    = 0;
  int         stray_n   = 0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_rx && err_frame) both_n++;
      if (done_rx) begin
        got_mem[got_n[7:0]] = data_rx;
        got_n++;
      end
      if (err_frame) err_n++;
      if (!done_rx && data_rx !== prev_data) stray_n++;
    end
    prev_data = data_rx;
  end

  // Reference model: what the receiver must report, in order.
  logic [7:0] exp_q [$];
  int         exp_err = 0;
  int         rd_n    = 0;
  int         err_rd  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CNT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one 8N1 frame; the model records the byte or the framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (stop_bit) exp_q.push_back(b);
    else          exp_err++;
  endtask

  // Compares everything the monitor logged since the last call with the model.
  task automatic check_group(input string tag);
    int n_exp;
    n_exp = exp_q.size();
    check({tag, "_count"}, got_n - rd_n, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (rd_n + i < got_n) check({tag, "_byte"}, got_mem[(rd_n + i) % 256], exp_q[i]);
    end
    check({tag, "_err"}, err_n - err_rd, exp_err);
    rd_n    = got_n;
    err_rd  = err_n;
    exp_q.delete();
    exp_err = 0;
  endtask

  initial begin
    int         waited;
    int         glen;
    logic [7:0] b;
    logic       stop_ok;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data_rx, 8'h00);
    check("rst_done", done_rx, 1'b0);
    check("rst_err",  err_frame, 1'b0);
    check("rst_busy", busy_rx, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Single bytes
    send_frame(8'h55, 1'b1);
    idle(CNT);
    send_frame(8'hA3, 1'b1);
    idle(CNT);
    check_group("single");
    check("single_hold", data_rx, 8'hA3);

    // Glitch rejection: short low pulses must be dropped at mid start bit
    for (int g = 0; g < 2; g++) begin
      glen = (g == 0) ? 4 : int'($urandom_range(1, HALF - 2));
      rx = 1'b0;
      repeat (glen) @(negedge clk);
      rx = 1'b1;
      waited = 0;
      while (busy_rx && waited <= HALF + 3) begin
        @(negedge clk);
        waited++;
      end
      check("glitch_busy", busy_rx, 1'b0);
      idle(CNT);
      check_group("glitch");
    end

    // Bad stop bit between two good frames
    send_frame(8'h11, 1'b1);
    idle(CNT);
    send_frame(8'h3C, 1'b0);
    idle(CNT);
    check("badstop_hold", data_rx, 8'h11);
    send_frame(8'h7E, 1'b1);
    idle(CNT);
    check_group("badstop");

    // Back-to-back frames with no idle time
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    idle(CNT);
    check_group("b2b");

    // Reset in the middle of data bit 4
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_data", data_rx, 8'h00);
    check("midrst_done", done_rx, 1'b0);
    check("midrst_err",  err_frame, 1'b0);
    check("midrst_busy", busy_rx, 1'b0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CNT);
    check_group("midrst_abort");
    send_frame(8'h5A, 1'b1);
    idle(CNT);
    check_group("midrst_next");

    // Break: line held low for two frame times gives one error, then nothing
    rx = 1'b0;
    repeat (20 * CNT) @(negedge clk);
    exp_err = 1;
    check_group("break");
    check("break_idle", busy_rx, 1'b0);
    idle(CNT);
    send_frame(8'hC3, 1'b1);
    idle(CNT);
    check_group("break_next");

    // Randomised frames, occasional bad stop bits and random idle gaps
    for (int k = 0; k < 24; k++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      send_frame(b, stop_ok);
      // After a bad stop the line must rise again before a new start can be seen.
      if (!stop_ok) idle(CNT);
      else          idle(int'($urandom_range(0, 3)));
    end
    idle(CNT);
    check_group("random");

    check("never_both",  both_n, 0);
    check("data_stable", stray_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound in case a wait above is ever broken.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver, 8N1, LSB first: the receiving end of the serial link driven by the `tx` block. It synchronises the asynchronous `rx` pin, finds each start bit, samples the data bits at mid-bit, and checks the stop bit. It presents each byte with a one-cycle `done_rx` strobe, or a one-cycle `err_frame` strobe when the stop bit is bad. It sits at the board pin on the receive side, opposite `tx`, and uses the same baud constants.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `CNT_MAX`, default CLK_FREQ/BAUD (integer division, 434): clocks per bit.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `rx`  input  1  serial line; idles high; asynchronous to `clk`.
- `data_rx`  output  8  last good byte; held until the next good byte.
- `done_rx`  output  1  one-cycle pulse: `data_rx` has just been updated.
- `err_frame`  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- `busy_rx`  output  1  high in every state except IDLE.

## Operation
- Synchroniser: two flops, reset to 1, produce `rx_s`. A third flop `rx_d` (reset 1) delays `rx_s`. Falling edge = `rx_d==1 && rx_s==0`.
- Baud counter `cnt`, width clog2(CNT_MAX). It is cleared on every state entry. It counts up while in START, DATA or STOP.
- Bit counter `bit_idx`, 3 bits.
- Shift register `shreg`, 8 bits. Each sampled data bit is shifted in at the MSB, so after 8 bits bit 0 holds the first (LSB-first) bit.
- States and transitions:
  - IDLE -> START on a falling edge.
  - START: when `cnt == CNT_MAX/2 - 1`, sample `rx_s`.
    - If `rx_s` is 1: false start (glitch); go to IDLE. No pulse.
    - If `rx_s` is 0: go to DATA, with `bit_idx = 0`.
  - DATA: when `cnt == CNT_MAX - 1`, sample `rx_s` into `shreg` and clear `cnt`.
    - If `bit_idx == 7`: go to STOP.
    - Otherwise: increment `bit_idx`.
  - STOP: when `cnt == CNT_MAX - 1`, sample `rx_s`.
    - If `rx_s` is 1: `data_rx <= shreg`, `done_rx <= 1`.
    - If `rx_s` is 0: `err_frame <= 1`; `data_rx` is unchanged.
    - Go to IDLE in both cases, at mid stop bit, so the receiver is re-armed for a start bit that follows immediately.
- A falling edge seen while not in IDLE is ignored.
- Break condition (line held low): one `err_frame`, then IDLE. No new frame starts until the line goes high and then falls again.
- Async reset, at any time including mid-frame:
  - state = IDLE; `cnt`, `bit_idx`, `shreg` = 0.
  - Synchroniser flops = 1.
  - Outputs: `data_rx` = 0x00, `done_rx` = 0, `err_frame` = 0, `busy_rx` = 0.
  - No pulse is generated by the aborted frame.

## Timing
- Pin-to-`rx_s` latency: 2 cycles. Falling edge is detected in the cycle `rx_s` first reads 0.
- Samples fall at START entry + CNT_MAX/2, then every CNT_MAX cycles: 1 start sample, 8 data samples, 1 stop sample.
- `done_rx` / `err_frame`:
  - Registered; high for exactly the one cycle after the stop sample.
  - Never high together.
  - Never high twice per frame.
- `data_rx` changes in the same cycle `done_rx` rises.
- `busy_rx` rises the cycle after the falling edge and falls in the cycle the pulse is high.
- No handshake and no buffering. The consumer must take `data_rx` before the next `done_rx`, at least 9.5 bit times later.
- Tolerance: the whole frame is sampled within ±CNT_MAX/2 of bit centre, so the design tolerates about ±4.5 % combined baud mismatch.

## Structure
- Shared package `uart_pkg`, also used by `tx`:
  - Defaults for CLK_FREQ and BAUD.
  - Function `baud_cnt(clk, baud)`.
  - The 2-bit state encoding IDLE/START/DATA/STOP.
- One sub-module, `bit_sync`: a 2-flop synchroniser with parameterised reset value, reusable for the `key` input path.
- Everything else lives in `uart_rx`.

## Test plan
- **Single bytes:** drive 0x55, then 0xA3, at 115200 baud from a bench UART model.
  - `done_rx` pulses once per byte, with `data_rx` = 0x55 then 0xA3.
  - `err_frame` stays 0.
- **Glitch rejection:** pull `rx` low for 100 clocks, then release.
  - No `done_rx` and no `err_frame`.
  - `busy_rx` returns to 0 within CNT_MAX/2 + 3 cycles.
- **Bad stop bit:** send 0x3C with the stop bit driven 0, after a good 0x11.
  - `err_frame` pulses once.
  - `data_rx` stays 0x11.
  - A following good 0x7E is received correctly.
- **Back-to-back frames:** send 0x00, 0xFF, 0x80 with zero idle time between them.
  - Three `done_rx` pulses with the correct values in order.
- **Reset mid-frame:** assert `rst_n` = 0 for 5 cycles during data bit 4.
  - All outputs go to 0 immediately.
  - The next full frame, 0x5A, is received correctly.
- **Loopback:** connect `tx` output to `uart_rx`; press the key 3 times.
  - `data_rx` sequence is 0x01, 0x02, 0x03.
